syndrome_decoder: RTL and testbench

SYNDROME_DECODER -- requirements
Module: syndrome_decoder

---
 rtl/syndrome_decoder_pkg.sv | 33 +++
 rtl/syndrome_decoder_if.sv | 34 +++
 rtl/syndrome_lut.sv | 44 ++++
 rtl/syndrome_decoder.sv | 116 +++++++++++
 tb/tb_syndrome_decoder.sv | 344 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/syndrome_decoder_pkg.sv
// Shared constants for the syndrome decoder: axis encoding, width helpers and
// reference decode tables for the 5-qubit code (stabilisers XZZXI and its cyclic shifts).
package syndrome_decoder_pkg;

    localparam int unsigned AXIS_X = 0;
    localparam int unsigned AXIS_Y = 1;
    localparam int unsigned AXIS_Z = 2;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(v)) r++;
        return r;
    endfunction

    function automatic int unsigned axis_width(input int unsigned naxis);
        return (clog2(naxis) > 1) ? clog2(naxis) : 1;
    endfunction

    // Entry [s] is the single-qubit correction for syndrome s; bit q flips qubit q.
    localparam logic [15:0][4:0] LUT_X_5Q = {
        5'b00000, 5'b00000, 5'b00000, 5'b10000, 5'b00000, 5'b00000, 5'b00000, 5'b00001,
        5'b00000, 5'b01000, 5'b00000, 5'b00000, 5'b00100, 5'b00000, 5'b00010, 5'b00000};

    localparam logic [15:0][4:0] LUT_Y_5Q = {
        5'b01000, 5'b10000, 5'b00001, 5'b00000, 5'b00010, 5'b00000, 5'b00000, 5'b00000,
        5'b00100, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000};

    localparam logic [15:0][4:0] LUT_Z_5Q = {
        5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00010, 5'b01000, 5'b00000,
        5'b00000, 5'b00000, 5'b00001, 5'b00100, 5'b00000, 5'b10000, 5'b00000, 5'b00000};

endpackage

// File: rtl/syndrome_decoder_if.sv
// Syndrome input, correction output, LUT programming and error-count signals.
interface syndrome_decoder_if #(
    parameter int unsigned NQ = 5,
    parameter int unsigned NS = 4,
    parameter int unsigned AW = 2
);
    logic          in_valid;
    logic          in_ready;
    logic [NS-1:0] in_syndrome;
    logic [AW-1:0] in_axis;
    logic          axis_clr;
    logic          lut_we;
    logic [AW-1:0] lut_axis;
    logic [NS-1:0] lut_addr;
    logic [NQ-1:0] lut_data;
    logic          out_valid;
    logic          out_ready;
    logic [NQ-1:0] out_correction;
    logic [AW-1:0] out_axis;
    logic          out_uncorr;
    logic [15:0]   err_count;

    modport master (
        output in_valid, in_syndrome, in_axis, axis_clr,
               lut_we, lut_axis, lut_addr, lut_data, out_ready,
        input  in_ready, out_valid, out_correction, out_axis, out_uncorr, err_count
    );

    modport slave (
        input  in_valid, in_syndrome, in_axis, axis_clr,
               lut_we, lut_axis, lut_addr, lut_data, out_ready,
        output in_ready, out_valid, out_correction, out_axis, out_uncorr, err_count
    );
endinterface

// File: rtl/syndrome_lut.sv
// Per-axis syndrome-to-correction table: registered storage with write decode and
// an asynchronous read, so a write lands for lookups starting the following cycle.
module syndrome_lut #(
    parameter int unsigned NQ    = 5,
    parameter int unsigned NS    = 4,
    parameter int unsigned NAXIS = 3,
    parameter int unsigned AW    = 2
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          we,
    input  logic [AW-1:0] wr_axis,
    input  logic [NS-1:0] wr_addr,
    input  logic [NQ-1:0] wr_data,
    input  logic [AW-1:0] rd_axis,
    input  logic [NS-1:0] rd_addr,
    output logic [NQ-1:0] rd_data
);
    localparam int unsigned DEPTH = 2 ** NS;

    logic [NQ-1:0] mem [NAXIS][DEPTH];

    // Writes to an axis with no storage match no entry and are dropped.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int a = 0; a < int'(NAXIS); a++)
                for (int s = 0; s < int'(DEPTH); s++)
                    mem[a][s] <= '0;
        end else begin
            for (int a = 0; a < int'(NAXIS); a++)
                for (int s = 0; s < int'(DEPTH); s++)
                    if (we && wr_axis == AW'(a) && wr_addr == NS'(s))
                        mem[a][s] <= wr_data;
        end
    end

    always_comb begin
        rd_data = '0;
        for (int a = 0; a < int'(NAXIS); a++)
            if (rd_axis == AW'(a))
                rd_data = mem[a][rd_addr];
    end

endmodule

// File: rtl/syndrome_decoder.sv
// Two-stage syndrome decoder: S1 captures syndrome and axis, S2 captures the table
// lookup; elastic valid/ready handshake with one-per-cycle throughput.
module syndrome_decoder
    import syndrome_decoder_pkg::*;
#(
    parameter int unsigned NQ       = 5,
    parameter int unsigned NS       = 4,
    parameter int unsigned NAXIS    = 3,
    parameter int unsigned AXIS_EXT = 0
) (
    input logic              CLK,
    input logic              RST,
    syndrome_decoder_if.slave bus
);
    localparam int unsigned    AW        = axis_width(NAXIS);
    localparam logic [AW:0]    NAXIS_W   = (AW+1)'(NAXIS);
    localparam logic [AW-1:0]  AXIS_LAST = AW'(NAXIS - 1);

    logic          s1_valid;
    logic [NS-1:0] s1_syn;
    logic [AW-1:0] s1_axis;
    logic          s2_valid;
    logic [NQ-1:0] s2_corr;
    logic [AW-1:0] s2_axis;
    logic          s2_uncorr;
    logic [AW-1:0] axis_cnt;
    logic [15:0]   err_cnt;

    logic          s2_adv;
    logic          in_ready_c;
    logic          accept;
    logic [AW-1:0] axis_sel;
    logic [NQ-1:0] lut_rd;
    logic          lookup_ok;
    logic [NQ-1:0] corr_nxt;
    logic          uncorr_nxt;

    syndrome_lut #(.NQ(NQ), .NS(NS), .NAXIS(NAXIS), .AW(AW)) u_lut (
        .CLK     (CLK),
        .RST     (RST),
        .we      (bus.lut_we),
        .wr_axis (bus.lut_axis),
        .wr_addr (bus.lut_addr),
        .wr_data (bus.lut_data),
        .rd_axis (s1_axis),
        .rd_addr (s1_syn),
        .rd_data (lut_rd)
    );

    // Handshake and lookup qualification; a zero syndrome or unknown axis never corrects.
    always_comb begin
        s2_adv     = !s2_valid || bus.out_ready;
        in_ready_c = !s1_valid || s2_adv;
        accept     = bus.in_valid && in_ready_c;
        axis_sel   = (AXIS_EXT != 0) ? bus.in_axis : axis_cnt;
        lookup_ok  = ({1'b0, s1_axis} < NAXIS_W) && (s1_syn != '0);
        corr_nxt   = lookup_ok ? lut_rd : '0;
        uncorr_nxt = lookup_ok && (lut_rd == '0);
    end

    // Round-robin axis; a clear wins over the increment of the same cycle.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            axis_cnt <= '0;
        else if (bus.axis_clr)
            axis_cnt <= '0;
        else if (accept)
            axis_cnt <= (axis_cnt == AXIS_LAST) ? '0 : axis_cnt + AW'(1);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            s1_valid <= 1'b0;
            s1_syn   <= '0;
            s1_axis  <= '0;
        end else if (in_ready_c) begin
            s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                s1_syn  <= bus.in_syndrome;
                s1_axis <= axis_sel;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            s2_valid  <= 1'b0;
            s2_corr   <= '0;
            s2_axis   <= '0;
            s2_uncorr <= 1'b0;
        end else if (s2_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_corr   <= corr_nxt;
                s2_axis   <= s1_axis;
                s2_uncorr <= uncorr_nxt;
            end
        end
    end

    // Counts uncorrectable results as they are handed off, saturating.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            err_cnt <= '0;
        else if (s2_valid && bus.out_ready && s2_uncorr && err_cnt != 16'hFFFF)
            err_cnt <= err_cnt + 16'd1;
    end

    assign bus.in_ready       = in_ready_c;
    assign bus.out_valid      = s2_valid;
    assign bus.out_correction = s2_corr;
    assign bus.out_axis       = s2_axis;
    assign bus.out_uncorr     = s2_uncorr;
    assign bus.err_count      = err_cnt;

endmodule

// File: tb/tb_syndrome_decoder.sv
// Self-checking bench for syndrome_decoder: directed scenarios plus a random stream
// scored against a table-and-queue reference model.
module tb_syndrome_decoder;
    import syndrome_decoder_pkg::*;

    localparam int unsigned NQ    = 5;
    localparam int unsigned NS    = 4;
    localparam int unsigned NAXIS = 3;
    localparam int unsigned AW    = axis_width(NAXIS);

    logic CLK;
    logic RST;
    int   n_assert;
    int   n_fail;

    syndrome_decoder_if #(.NQ(NQ), .NS(NS), .AW(AW)) bus ();
    syndrome_decoder_if #(.NQ(NQ), .NS(NS), .AW(AW)) bx ();

    syndrome_decoder #(.NQ(NQ), .NS(NS), .NAXIS(NAXIS), .AXIS_EXT(0)) dut (
        .CLK(CLK), .RST(RST), .bus(bus));
    syndrome_decoder #(.NQ(NQ), .NS(NS), .NAXIS(NAXIS), .AXIS_EXT(1)) dut_ext (
        .CLK(CLK), .RST(RST), .bus(bx));

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [NQ-1:0] corr;
        logic [AW-1:0] axis;
        logic          unc;
    } exp_t;

    exp_t          exp_q[$];
    logic [NQ-1:0] m_lut [NAXIS][16];
    int            m_cnt;
    int            m_err;
    logic [AW-1:0] fired_axis[$];
    logic [NQ-1:0] fired_corr[$];
    logic          fired_unc[$];
    logic          last_acc;
    logic          last_ready;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t ref_lookup(input int syn, input int axis);
        exp_t e;
        e.axis = AW'(axis);
        e.corr = '0;
        e.unc  = 1'b0;
        if (syn != 0 && axis < int'(NAXIS)) begin
            e.corr = m_lut[axis][syn];
            e.unc  = (e.corr == '0);
        end
        return e;
    endfunction

    task automatic model_reset();
        exp_q.delete();
        for (int a = 0; a < int'(NAXIS); a++)
            for (int s = 0; s < 16; s++)
                m_lut[a][s] = '0;
        m_cnt = 0;
        m_err = 0;
    endtask

    task automatic clear_logs();
        fired_axis.delete();
        fired_corr.delete();
        fired_unc.delete();
    endtask

    // One clock of the main DUT: score outputs and update the model at mid-cycle.
    task automatic tick();
        @(negedge CLK);
        if (bus.out_valid) begin
            if (exp_q.size() == 0) begin
                chk("stale_out_valid", 32'(bus.out_valid), 32'd0);
            end else begin
                chk("out_correction", 32'(bus.out_correction), 32'(exp_q[0].corr));
                chk("out_axis", 32'(bus.out_axis), 32'(exp_q[0].axis));
                chk("out_uncorr", 32'(bus.out_uncorr), 32'(exp_q[0].unc));
                if (bus.out_ready) begin
                    fired_axis.push_back(bus.out_axis);
                    fired_corr.push_back(bus.out_correction);
                    fired_unc.push_back(bus.out_uncorr);
                    if (exp_q[0].unc && m_err < 65535) m_err++;
                    void'(exp_q.pop_front());
                end
            end
        end
        last_ready = bus.in_ready;
        last_acc   = bus.in_valid && bus.in_ready;
        if (last_acc) exp_q.push_back(ref_lookup(int'(bus.in_syndrome), m_cnt));
        if (bus.axis_clr) m_cnt = 0;
        else if (last_acc) m_cnt = (m_cnt + 1) % int'(NAXIS);
        if (bus.lut_we && int'(bus.lut_axis) < int'(NAXIS))
            m_lut[bus.lut_axis][bus.lut_addr] = bus.lut_data;
        @(posedge CLK);
        #1;
        chk("err_count", 32'(bus.err_count), 32'(m_err));
    endtask

    task automatic send(input logic [NS-1:0] syn);
        bus.in_valid    = 1'b1;
        bus.in_syndrome = syn;
        tick();
    endtask

    task automatic lut_wr(input int axis, input int addr, input logic [NQ-1:0] data);
        bus.lut_we   = 1'b1;
        bus.lut_axis = AW'(axis);
        bus.lut_addr = NS'(addr);
        bus.lut_data = data;
        tick();
        bus.lut_we   = 1'b0;
    endtask

    task automatic pulse_clr();
        bus.axis_clr = 1'b1;
        tick();
        bus.axis_clr = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        while ((exp_q.size() != 0 || bus.out_valid) && n < 20) begin
            tick();
            n++;
        end
        chk("drain_pending", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: observed no finish, required finish within 200000 time units");
        $fatal(1, "simulation timeout");
    end

    initial begin
        logic [NS-1:0] stall_syn [5];
        int            idx;
        int            stall_acc;
        logic          hold;

        n_assert = 0;
        n_fail   = 0;
        last_acc = 1'b0;
        last_ready = 1'b0;
        {bus.in_valid, bus.in_syndrome, bus.in_axis, bus.axis_clr} = '0;
        {bus.lut_we, bus.lut_axis, bus.lut_addr, bus.lut_data} = '0;
        {bx.in_valid, bx.in_syndrome, bx.in_axis, bx.axis_clr} = '0;
        {bx.lut_we, bx.lut_axis, bx.lut_addr, bx.lut_data} = '0;
        bus.out_ready = 1'b1;
        bx.out_ready  = 1'b1;
        RST = 1'b1;
        model_reset();
        clear_logs();
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        @(posedge CLK);
        #1;

        // Reset state
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_err_count", 32'(bus.err_count), 32'd0);
        chk("rst_out_correction", 32'(bus.out_correction), 32'd0);
        chk("rst_out_axis", 32'(bus.out_axis), 32'd0);
        chk("rst_out_uncorr", 32'(bus.out_uncorr), 32'd0);

        // Empty table: nonzero syndrome is uncorrectable, zero syndrome is not
        send(4'b0110);
        send(4'b0000);
        drain();
        chk("empty_err_count", 32'(bus.err_count), 32'd1);
        chk("empty_n_out", 32'(fired_unc.size()), 32'd2);
        chk("empty_unc_0110", 32'(fired_unc[0]), 32'd1);
        chk("empty_unc_0000", 32'(fired_unc[1]), 32'd0);

        // Back-to-back X then Y lookups with two-cycle latency
        pulse_clr();
        lut_wr(AXIS_X, 1, 5'b10000);
        lut_wr(AXIS_Y, 11, 5'b10000);
        clear_logs();
        send(4'b0001);
        send(4'b1011);
        bus.in_valid = 1'b0;
        chk("lat_c2_valid", 32'(bus.out_valid), 32'd1);
        chk("lat_c2_corr", 32'(bus.out_correction), 32'b10000);
        chk("lat_c2_axis", 32'(bus.out_axis), 32'd0);
        tick();
        chk("lat_c3_valid", 32'(bus.out_valid), 32'd1);
        chk("lat_c3_corr", 32'(bus.out_correction), 32'b10000);
        chk("lat_c3_axis", 32'(bus.out_axis), 32'd1);
        drain();

        // Axis clear coinciding with the third input
        pulse_clr();
        clear_logs();
        send(4'b0101);
        send(4'b0110);
        bus.axis_clr = 1'b1;
        send(4'b0111);
        bus.axis_clr = 1'b0;
        send(4'b1001);
        drain();
        chk("clr_n_out", 32'(fired_axis.size()), 32'd4);
        chk("clr_axis0", 32'(fired_axis[0]), 32'd0);
        chk("clr_axis1", 32'(fired_axis[1]), 32'd1);
        chk("clr_axis2", 32'(fired_axis[2]), 32'd2);
        chk("clr_axis3", 32'(fired_axis[3]), 32'd0);

        // Table write racing a lookup of the same entry returns the old contents
        pulse_clr();
        clear_logs();
        send(4'b0011);
        bus.in_valid = 1'b0;
        lut_wr(AXIS_X, 3, 5'b00001);
        drain();
        pulse_clr();
        send(4'b0011);
        drain();
        chk("race_n_out", 32'(fired_corr.size()), 32'd2);
        chk("race_old_corr", 32'(fired_corr[0]), 32'd0);
        chk("race_old_unc", 32'(fired_unc[0]), 32'd1);
        chk("race_new_corr", 32'(fired_corr[1]), 32'b00001);

        // Backpressure: three stalled cycles under a continuous stream
        clear_logs();
        for (int i = 0; i < 5; i++) stall_syn[i] = NS'($urandom_range(1, 15));
        idx = 0;
        stall_acc = 0;
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (i == 3) bus.out_ready = 1'b1;
            bus.in_syndrome = stall_syn[idx];
            tick();
            if (i < 3) begin
                chk("stall_in_ready", 32'(last_ready), (i < 2) ? 32'd1 : 32'd0);
                if (last_acc) stall_acc++;
            end
            if (last_acc) idx++;
        end
        bus.in_valid = 1'b0;
        drain();
        chk("stall_accepted", 32'(stall_acc), 32'd2);
        chk("stall_n_out", 32'(fired_corr.size()), 32'd5);

        // Random stream against the full 5-qubit tables
        for (int s = 0; s < 16; s++) begin
            lut_wr(AXIS_X, s, LUT_X_5Q[s]);
            lut_wr(AXIS_Y, s, LUT_Y_5Q[s]);
            lut_wr(AXIS_Z, s, LUT_Z_5Q[s]);
        end
        hold = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (!hold) begin
                bus.in_valid    = ($urandom_range(0, 3) != 0);
                bus.in_syndrome = NS'($urandom);
            end
            bus.out_ready = ($urandom_range(0, 3) != 0);
            bus.axis_clr  = ($urandom_range(0, 15) == 0);
            tick();
            hold = bus.in_valid && !last_acc;
        end
        bus.axis_clr = 1'b0;
        drain();

        // External axis selection on the second instance
        bx.lut_we   = 1'b1;
        bx.lut_axis = 2'd2;
        bx.lut_addr = 4'd5;
        bx.lut_data = 5'b00100;
        tick();
        bx.lut_axis = 2'd3;
        bx.lut_data = 5'b11111;
        tick();
        bx.lut_we      = 1'b0;
        bx.in_valid    = 1'b1;
        bx.in_syndrome = 4'd5;
        bx.in_axis     = 2'd3;
        tick();
        bx.in_axis = 2'd2;
        tick();
        chk("ext_bad_axis_corr", 32'(bx.out_correction), 32'd0);
        chk("ext_bad_axis_unc", 32'(bx.out_uncorr), 32'd0);
        chk("ext_bad_axis_axis", 32'(bx.out_axis), 32'd3);
        bx.in_axis = 2'd0;
        tick();
        bx.in_valid = 1'b0;
        chk("ext_axis2_corr", 32'(bx.out_correction), 32'b00100);
        chk("ext_axis2_axis", 32'(bx.out_axis), 32'd2);
        tick();
        chk("ext_axis0_corr", 32'(bx.out_correction), 32'd0);
        chk("ext_axis0_unc", 32'(bx.out_uncorr), 32'd1);
        tick();
        chk("ext_err_count", 32'(bx.err_count), 32'd1);
        chk("ext_idle", 32'(bx.out_valid), 32'd0);

        // Reset with two items in flight
        bus.out_ready = 1'b0;
        send(4'b1000);
        send(4'b0001);
        bus.in_valid = 1'b0;
        chk("inflight_valid", 32'(bus.out_valid), 32'd1);
        chk("inflight_in_ready", 32'(bus.in_ready), 32'd0);
        chk("inflight_err_nonzero", 32'(bus.err_count != 16'd0), 32'd1);
        #2;
        RST = 1'b1;
        #1;
        chk("async_rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("async_rst_err_count", 32'(bus.err_count), 32'd0);
        chk("async_rst_ext_err", 32'(bx.err_count), 32'd0);
        model_reset();
        clear_logs();
        @(negedge CLK);
        RST = 1'b0;
        @(posedge CLK);
        #1;
        chk("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
        bus.out_ready = 1'b1;
        repeat (5) tick();
        chk("post_rst_no_output", 32'(fired_corr.size()), 32'd0);
        pulse_clr();
        send(4'b1000);
        drain();
        chk("post_rst_lut_cleared", 32'(fired_unc[0]), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
